// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider (clk_div_ctrl).
// The optional run/stop gate is enabled by defining CLKDIV_GATE_EN.
package clk_div_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int MIN_DIV   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter, active ratio register and registered clk_out/tick generation.
// Ratio writes are taken at IDLE or on a wrap, so a period always runs at one ratio.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             start,
   input  logic             run,
   input  logic             stop,
   input  logic             div_we,
   input  logic [CNT_W-1:0] div_wdata,
   output logic             wrap,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] div_nxt;

   assign wrap    = run && (cnt == div - 1'b1);
   assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
   // On a wrap the high phase of the new period is judged against the ratio it starts with
   assign div_nxt = div_we ? div_wdata : div;

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         cnt     <= '0;
         div     <= CNT_W'(DEFAULT_DIV);
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (start) begin
         cnt     <= '0;
         div     <= div_nxt;
         clk_out <= 1'b1;
         tick    <= 1'b1;
      end else if (wrap && stop) begin
         cnt     <= '0;
         div     <= div_nxt;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (run) begin
         cnt     <= cnt_nxt;
         div     <= div_nxt;
         clk_out <= (cnt_nxt < (div_nxt >> 1));
         tick    <= wrap;
      end else begin
         cnt     <= '0;
         div     <= div_nxt;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: FSM, pending-ratio register and cfg handshake.
// Define CLKDIV_GATE_EN to add the enable port that stops the divider at a period boundary.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
`ifdef CLKDIV_GATE_EN
   input  logic             enable,
`endif
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] pend;
   logic             run_req;
   logic             accept;
   logic             div_ok;
   logic             wrap;
   logic             start;
   logic             run;
   logic             stop;
   logic             div_we;
   logic [CNT_W-1:0] div_wdata;

`ifdef CLKDIV_GATE_EN
   assign run_req = enable;
`else
   assign run_req = 1'b1;
`endif

   assign accept = cfg_valid && (state != PEND);
   assign div_ok = accept && (cfg_div >= CNT_W'(MIN_DIV));
   assign start  = (state == IDLE) && run_req;
   assign run    = (state != IDLE);
   assign stop   = !run_req;

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state   <= IDLE;
         pend    <= '0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cfg_err <= accept && (cfg_div < CNT_W'(MIN_DIV));
         if ((state == RUN) && div_ok && !wrap)
            pend <= cfg_div;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (run_req) state_nxt = RUN;
         RUN: begin
            if (wrap)
               state_nxt = run_req ? RUN : IDLE;
            else if (div_ok)
               state_nxt = PEND;
         end
         PEND: if (wrap) state_nxt = run_req ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A ratio accepted on a wrap edge bypasses pend and lands directly in the core
   always_comb begin
      cfg_ready = (state != PEND);
      busy      = (state != IDLE);
      div_we    = 1'b0;
      div_wdata = cfg_div;
      case (state)
         IDLE: div_we = div_ok;
         RUN:  div_we = div_ok && wrap;
         PEND: begin
            div_we    = wrap;
            div_wdata = pend;
         end
         default: div_we = 1'b0;
      endcase
   end

   clk_div_core #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_core (
      .clk_in    (clk_in),
      .reset     (reset),
      .start     (start),
      .run       (run),
      .stop      (stop),
      .div_we    (div_we),
      .div_wdata (div_wdata),
      .wrap      (wrap),
      .clk_out   (clk_out),
      .tick      (tick)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios then random traffic against a period-level model.
// The enable scenario is only built when CLKDIV_GATE_EN is defined.
module tb_clk_div_ctrl;

   localparam int CNT_W = 8;
   localparam int DEF   = 4;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_out;
   logic             tick;
   logic             busy;
`ifdef CLKDIV_GATE_EN
   logic             enable;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: running flag, ratio, optional pending ratio, position in period
   bit m_run, m_pv, m_clk, m_tick, m_err;
   int m_ratio, m_pos, m_pval;

   clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
`ifdef CLKDIV_GATE_EN
      .enable    (enable),
`endif
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit run_req();
`ifdef CLKDIV_GATE_EN
      return (enable === 1'b1);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit acc, good;
      if (!reset) begin
         m_run = 0; m_pv = 0; m_ratio = DEF; m_pos = 0;
         m_clk = 0; m_tick = 0; m_err = 0;
      end else begin
         acc   = cfg_valid && !m_pv;
         good  = acc && (int'(cfg_div) >= 2);
         m_err = acc && !good;
         if (!m_run) begin
            if (good) m_ratio = int'(cfg_div);
            if (run_req()) begin
               m_run = 1; m_pos = 0; m_clk = 1; m_tick = 1;
            end else begin
               m_clk = 0; m_tick = 0;
            end
         end else if (m_pos == m_ratio - 1) begin
            if (m_pv) begin
               m_ratio = m_pval; m_pv = 0;
            end else if (good) begin
               m_ratio = int'(cfg_div);
            end
            m_pos = 0;
            if (run_req()) begin
               m_clk = 1; m_tick = 1;
            end else begin
               m_run = 0; m_clk = 0; m_tick = 0;
            end
         end else begin
            if (good) begin
               m_pv = 1; m_pval = int'(cfg_div);
            end
            m_pos++;
            m_clk  = (m_pos < m_ratio / 2);
            m_tick = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      model_update();
      @(negedge clk_in);
      check("clk_out", clk_out, m_clk);
      check("tick", tick, m_tick);
      check("busy", busy, m_run);
      check("cfg_ready", cfg_ready, !m_pv);
      check("cfg_err", cfg_err, m_err);
   endtask

   // p < 0 selects the last cycle of the current period
   task automatic wait_pos(input int p);
      int  guard = 0;
      bit  found = 0;
      while (!found && guard < 200) begin
         if (m_run && !m_pv && (m_pos == ((p < 0) ? m_ratio - 1 : p))) found = 1;
         else begin step(); guard++; end
      end
      check("wait_pos", found, 1);
   endtask

   task automatic measure_period(input string tag, input int len, input int hi);
      int n = 0, h = 0, guard = 0;
      while (tick !== 1'b1 && guard < 300) begin step(); guard++; end
      check({tag, "_start"}, tick, 1);
      do begin
         h += (clk_out === 1'b1) ? 1 : 0;
         n++;
         step();
      end while (tick !== 1'b1 && n < 300);
      check({tag, "_len"}, n, len);
      check({tag, "_high"}, h, hi);
   endtask

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
`ifdef CLKDIV_GATE_EN
      enable = 1'b1;
`endif
      step(); step();
      check("rst_ready", cfg_ready, 1);
      check("rst_clk", clk_out, 0);
      reset = 1'b1;

      // default ratio straight out of reset
      step();
      check("t1_first_tick", tick, 1);
      check("t1_first_high", clk_out, 1);
      measure_period("t1_a", 4, 2);
      measure_period("t1_b", 4, 2);

      // illegal ratios are acknowledged and ignored
      wait_pos(1);
      cfg_valid = 1'b1; cfg_div = 8'd1; step();
      check("t3_err1", cfg_err, 1);
      cfg_div = 8'd0; step();
      check("t3_err0", cfg_err, 1);
      cfg_valid = 1'b0; step();
      check("t3_err_clear", cfg_err, 0);
      measure_period("t3", 4, 2);

      // mid-period change waits for the boundary
      wait_pos(1);
      cfg_valid = 1'b1; cfg_div = 8'd3; step();
      cfg_valid = 1'b0;
      check("t2_ready_low", cfg_ready, 0);
      measure_period("t2_a", 3, 1);
      check("t2_ready_back", cfg_ready, 1);
      measure_period("t2_b", 3, 1);

      // change accepted exactly on the wrap edge
      wait_pos(-1);
      cfg_valid = 1'b1; cfg_div = 8'd6; step();
      cfg_valid = 1'b0;
      check("t4_tick", tick, 1);
      check("t4_ready", cfg_ready, 1);
      measure_period("t4", 6, 3);

      // reset in the high phase with a ratio pending
      wait_pos(0);
      cfg_valid = 1'b1; cfg_div = 8'd5; step();
      cfg_valid = 1'b0;
      check("t5_high", clk_out, 1);
      check("t5_pend", cfg_ready, 0);
      reset = 1'b0; step();
      check("t5_clk", clk_out, 0);
      check("t5_tick", tick, 0);
      check("t5_ready", cfg_ready, 1);
      reset = 1'b1; step();
      check("t5_restart", tick, 1);
      measure_period("t5", 4, 2);

`ifdef CLKDIV_GATE_EN
      // stop at the end of an N=8 period, then restart
      cfg_valid = 1'b1; cfg_div = 8'd8; step();
      cfg_valid = 1'b0;
      wait_pos(1);
      check("t6_ratio", m_ratio, 8);
      enable = 1'b0;
      repeat (6) step();
      check("t6_still_busy", busy, 1);
      step();
      check("t6_idle_busy", busy, 0);
      check("t6_idle_clk", clk_out, 0);
      step();
      check("t6_stay_idle", busy, 0);
      enable = 1'b1; step();
      check("t6_restart_clk", clk_out, 1);
      check("t6_restart_tick", tick, 1);
      measure_period("t6", 8, 4);
`endif

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_div   = CNT_W'($urandom_range(0, 9));
         reset     = ($urandom_range(0, 149) != 0);
`ifdef CLKDIV_GATE_EN
         enable    = ($urandom_range(0, 19) != 0);
`endif
         step();
      end
      cfg_valid = 1'b0; reset = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
